// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the iterative shift-add multiplier (seq_mult_unit):
//   - state_t        : FSM states IDLE -> RUN -> FIX -> IDLE
//   - DEFAULT_WIDTH  : default operand width
//   - bpc_legal()    : tells whether a BITS_PER_CYCLE value suits a WIDTH
//   - iter_count()   : number of RUN iterations for a WIDTH/BITS_PER_CYCLE pair
// No ports (package).
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Only radix 2, 4 and 16 digits are supported, and the digits must tile
    // the multiplier exactly so the final alignment comes out right.
    function automatic bit bpc_legal(input int width, input int bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4)) &&
               (width > 0) && ((width % bpc) == 0);
    endfunction

    // Iterations needed to consume the whole multiplier. An illegal pairing
    // returns 1 so that dependent widths stay sane while elaboration reports
    // the error.
    function automatic int iter_count(input int width, input int bpc);
        return bpc_legal(width, bpc) ? (width / bpc) : 1;
    endfunction

endpackage

// File: rtl/mult_step.sv
// ---------------------------------------------------------------------------
// mult_step
// One combinational shift-add iteration. The multiplicand times the current
// multiplier digit is added into the upper part of the accumulator, then the
// whole accumulator is shifted right by one digit.
// Ports:
//   mcand    in  WIDTH            multiplicand magnitude
//   digit    in  BITS_PER_CYCLE   current low multiplier digit
//   acc      in  2*WIDTH+BPC      current accumulator
//   acc_next out 2*WIDTH+BPC      accumulator after add and shift
// ---------------------------------------------------------------------------
module mult_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0]                  mcand,
    input  logic [BITS_PER_CYCLE-1:0]         digit,
    input  logic [2*WIDTH+BITS_PER_CYCLE-1:0] acc,
    output logic [2*WIDTH+BITS_PER_CYCLE-1:0] acc_next
);

    localparam int UW = WIDTH + BITS_PER_CYCLE;

    logic [UW-1:0] partial;
    logic [UW-1:0] upper_sum;

    // The upper slice holds less than 2^WIDTH before the add and the partial
    // product is below 2^WIDTH * (2^BPC - 1), so the sum always fits in
    // WIDTH+BPC bits and no carry is ever dropped. The shift then brings the
    // accumulator back into position for the next digit.
    always_comb begin
        partial   = {{BITS_PER_CYCLE{1'b0}}, mcand} * {{WIDTH{1'b0}}, digit};
        upper_sum = acc[2*WIDTH+BITS_PER_CYCLE-1:WIDTH] + partial;
        acc_next  = {upper_sum, acc[WIDTH-1:0]} >> BITS_PER_CYCLE;
    end

endmodule

// File: rtl/seq_mult_unit.sv
// ---------------------------------------------------------------------------
// seq_mult_unit
// Iterative shift-add multiplier for MULT/MULTU. Operands are converted to
// magnitudes at start, BITS_PER_CYCLE multiplier bits are retired per clock,
// and the sign is applied in a final FIX cycle.
// Optional feature macro: MULT_EARLY_TERM_EN (skip to FIX once the remaining
// multiplier is zero, aligning the accumulator with a barrel shift).
// Ports:
//   clk    in  1        clock, rising edge
//   reset  in  1        asynchronous active-high reset
//   start  in  1        request, sampled only in IDLE
//   sign   in  1        1 = signed operands, 0 = unsigned
//   a      in  WIDTH    multiplicand
//   b      in  WIDTH    multiplier
//   busy   out 1        operation in progress
//   done   out 1        one-cycle pulse, z holds a new result
//   z      out 2*WIDTH  product {hi, lo}
// ---------------------------------------------------------------------------
module seq_mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sign,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z
);

    localparam int N  = iter_count(WIDTH, BITS_PER_CYCLE);
    localparam int CW = $clog2(N + 1);
    localparam int AW = 2*WIDTH + BITS_PER_CYCLE;

    // Refuse to build a multiplier whose digits would not tile the operand.
    generate
        if (!bpc_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_bpc
            $error("seq_mult_unit: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  b_mag;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_step;
    logic [CW-1:0]     cnt;
    logic              neg;
    logic              skip_run;

    mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .mcand    (mcand),
        .digit    (b_mag[BITS_PER_CYCLE-1:0]),
        .acc      (acc),
        .acc_next (acc_step)
    );

    // With early termination the remaining multiplier digits are all zero
    // once b_mag is empty, so the rest of RUN would only shift; the default
    // build keeps the fixed latency and has no zero detector at all.
    always_comb begin
`ifdef MULT_EARLY_TERM_EN
        skip_run = (b_mag == '0);
`else
        skip_run = 1'b0;
`endif
    end

    // State register. Reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a request is only taken in IDLE, RUN lasts until the
    // counter expires (or the multiplier empties when early termination is
    // built in), and FIX always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (skip_run || (cnt == CW'(1))) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: busy covers every RUN cycle plus the FIX cycle, so it
    // drops on the same edge that writes z and raises done.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath registers. Operands become magnitudes at start so the RUN loop
    // is purely unsigned; the product sign is remembered in neg and applied
    // in FIX. z is only written in FIX, so it holds the previous result while
    // a new operation is running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            b_mag <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            z     <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= (sign && a[WIDTH-1]) ? -a : a;
                        b_mag <= (sign && b[WIDTH-1]) ? -b : b;
                        neg   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= CW'(N);
                    end
                end
                RUN: begin
                    if (skip_run) begin
                        acc <= acc >> (32'(cnt) * BITS_PER_CYCLE);
                    end else begin
                        acc   <= acc_step;
                        b_mag <= b_mag >> BITS_PER_CYCLE;
                        cnt   <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    z <= neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_unit
// Scoreboard bench for seq_mult_unit: a 32-bit radix-2 instance and a 16-bit
// radix-16 instance. Expected products are hand-computed constants pushed
// into per-instance queues; monitors pop and compare on every done pulse.
// ---------------------------------------------------------------------------
module tb_seq_mult_unit;

    typedef struct {
        logic [63:0] z;
        int          lat_min;
        int          lat_max;
        int          start_cyc;
    } exp_t;

`ifdef MULT_EARLY_TERM_EN
    localparam int ET32_LO = 2;
    localparam int ET32_HI = 32;
    localparam int ET16_LO = 2;
    localparam int ET16_HI = 4;
    localparam int INJECT  = 1;
`else
    localparam int ET32_LO = 33;
    localparam int ET32_HI = 33;
    localparam int ET16_LO = 5;
    localparam int ET16_HI = 5;
    localparam int INJECT  = 8;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start32 = 1'b0;
    logic        sign32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        busy32;
    logic        done32;
    logic [63:0] z32;

    logic        start16 = 1'b0;
    logic        sign16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16;
    logic        done16;
    logic [31:0] z16;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done32_seen = 0;
    int   done16_seen = 0;
    int   busy32_cnt = 0;
    int   busy16_cnt = 0;
    exp_t q32[$];
    exp_t q16[$];

    seq_mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .sign(sign32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .z(z32)
    );

    seq_mult_unit #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .sign(sign16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .z(z16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    // Called between a negedge and the next posedge; start is sampled at the
    // next posedge (cycle cyc+1). Inputs are scrambled afterwards to show the
    // operands were captured.
    task automatic applyStimulus32(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   input logic [63:0] z, input int lo, input int hi);
        exp_t e;
        a32 = a; b32 = b; sign32 = s; start32 = 1'b1;
        e.z = z; e.lat_min = lo; e.lat_max = hi; e.start_cyc = cyc + 1;
        q32.push_back(e);
        @(negedge clk); #1;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; sign32 = 1'($urandom);
    endtask

    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, input logic s,
                                   input logic [31:0] z, input int lo, input int hi);
        exp_t e;
        a16 = a; b16 = b; sign16 = s; start16 = 1'b1;
        e.z = {32'h0, z}; e.lat_min = lo; e.lat_max = hi; e.start_cyc = cyc + 1;
        q16.push_back(e);
        @(negedge clk); #1;
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sign16 = 1'($urandom);
    endtask

    task automatic waitDone32(input int budget);
        int base = done32_seen;
        int n = 0;
        while (done32_seen == base && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (done32_seen == base) begin
            checks++; errors++;
            $display("[TB] FAIL timeout32: no done within %0d cycles", budget);
        end
    endtask

    task automatic waitDone16(input int budget);
        int base = done16_seen;
        int n = 0;
        while (done16_seen == base && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (done16_seen == base) begin
            checks++; errors++;
            $display("[TB] FAIL timeout16: no done within %0d cycles", budget);
        end
    endtask

    // Monitor for the 32-bit instance: every done pulse must match the oldest
    // queued expectation in value, latency and busy duration.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy32_cnt = 0;
            end else begin
                if (done32) begin
                    if (q32.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL done32: unexpected pulse, z=0x%0h, expected none", z32);
                    end else begin
                        e = q32.pop_front();
                        checkOutput("z32", z32, e.z);
                        checkRange("latency32", cyc - e.start_cyc, e.lat_min, e.lat_max);
                        checkRange("busy32", busy32_cnt, e.lat_min, e.lat_max);
                    end
                    busy32_cnt = 0;
                    done32_seen++;
                end
                if (busy32) busy32_cnt++;
            end
        end
    end

    // Monitor for the 16-bit radix-16 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy16_cnt = 0;
            end else begin
                if (done16) begin
                    if (q16.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL done16: unexpected pulse, z=0x%0h, expected none", z16);
                    end else begin
                        e = q16.pop_front();
                        checkOutput("z16", {32'h0, z16}, e.z);
                        checkRange("latency16", cyc - e.start_cyc, e.lat_min, e.lat_max);
                        checkRange("busy16", busy16_cnt, e.lat_min, e.lat_max);
                    end
                    busy16_cnt = 0;
                    done16_seen++;
                end
                if (busy16) busy16_cnt++;
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset busy32", {63'h0, busy32}, 64'h0);
        checkOutput("reset done32", {63'h0, done32}, 64'h0);
        checkOutput("reset z32", z32, 64'h0);
        checkOutput("reset busy16", {63'h0, busy16}, 64'h0);
        checkOutput("reset z16", {32'h0, z16}, 64'h0);
        #1 reset = 1'b0;
        @(negedge clk); #1;

        // Unsigned all-ones, then signed pair issued back to back.
        applyStimulus32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 33, 33);
        waitDone32(40);
        applyStimulus32(32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFF1, ET32_LO, ET32_HI);
        waitDone32(40);
        applyStimulus32(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 33, 33);
        waitDone32(40);

        repeat (3) @(negedge clk);
        checkOutput("z32 hold", z32, 64'h4000000000000000);
        #1;

        // Start during busy must be ignored.
        applyStimulus32(32'd7, 32'd9, 1'b0, 64'd63, ET32_LO, ET32_HI);
        repeat (INJECT) @(negedge clk);
        #1;
        a32 = 32'd2; b32 = 32'd2; sign32 = 1'b0; start32 = 1'b1;
        @(negedge clk); #1;
        start32 = 1'b0;
        waitDone32(40);
        repeat (40) @(negedge clk);
        checkOutput("z32 after ignored start", z32, 64'd63);
        #1;

        // Reset mid-operation aborts; the queued entry is discarded.
        applyStimulus32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h0, 33, 33);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        q32.delete();
        @(negedge clk);
        checkOutput("abort busy32", {63'h0, busy32}, 64'h0);
        checkOutput("abort z32", z32, 64'h0);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        applyStimulus32(32'd6, 32'd7, 1'b0, 64'd42, ET32_LO, ET32_HI);
        waitDone32(40);

        // Small multiplier (early-termination candidate) and edge cases.
        applyStimulus32(32'd7, 32'd3, 1'b0, 64'd21, ET32_LO, ET32_HI);
        waitDone32(40);
        applyStimulus32(32'd0, 32'hFFFFFFFB, 1'b1, 64'h0, ET32_LO, ET32_HI);
        waitDone32(40);
        applyStimulus32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1, ET32_LO, ET32_HI);
        waitDone32(40);
        applyStimulus32(32'h80000000, 32'd2, 1'b0, 64'h100000000, ET32_LO, ET32_HI);
        waitDone32(40);

        // Radix-16, 16-bit instance.
        applyStimulus16(16'h1234, 16'h5678, 1'b0, 32'h06260060, 5, 5);
        waitDone16(20);
        applyStimulus16(16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA, ET16_LO, ET16_HI);
        waitDone16(20);
        applyStimulus16(16'h8000, 16'h8000, 1'b1, 32'h40000000, 5, 5);
        waitDone16(20);

        repeat (5) @(negedge clk);
        checkOutput("queues drained", 64'(q32.size() + q16.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
- Parametrised iterative shift-add multiplier for the CPU execute stage. It serves MULT/MULTU and feeds HI/LO.
- Operands are WIDTH bits wide, signed or unsigned. The block retires BITS_PER_CYCLE multiplier bits per clock and uses a start/busy/done handshake.
- Operand signs are captured at start, so the result never depends on inputs that change mid-operation.

Parameters:
- WIDTH, 32: operand width. Product is 2*WIDTH bits.
- BITS_PER_CYCLE, 1: multiplier bits consumed per iteration. Legal values are 1, 2 and 4, and the value must divide WIDTH. Otherwise elaboration fails.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  request. Sampled only in IDLE.
- sign  in  1  1 = signed (two's complement) operands, 0 = unsigned. Captured with the operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when z holds a new result.
- z  out  2*WIDTH  product. {hi, lo} = z[2W-1:W], z[W-1:0].

Behaviour:
- Reset values: busy=0, done=0, z=0, state=IDLE, and all internal registers 0. Reset mid-operation aborts the operation immediately and discards it. No done pulse is produced.
- State machine: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1:
  - Latch the magnitudes. If sign=1 and the MSB is set, store the operand negated; otherwise store it as is.
  - Latch neg = sign & (a[MSB] ^ b[MSB]).
  - Clear the accumulator, load the iteration counter with N = WIDTH/BITS_PER_CYCLE, and go to RUN. busy rises at that edge.
- RUN, each cycle:
  - Add mcand * b_mag[BITS_PER_CYCLE-1:0] to the upper half of the accumulator. The accumulator is 2W+BITS_PER_CYCLE bits, so no carry is lost.
  - Shift the accumulator right and b_mag right by BITS_PER_CYCLE, then decrement the counter.
  - After N RUN cycles go to FIX.
- FIX, one cycle:
  - z <= neg ? (0 - acc[2W-1:0]) : acc[2W-1:0], computed modulo 2^(2W).
  - done=1 for this cycle only. busy falls at the same edge, and the state returns to IDLE.
- Latency: start sampled at edge 0, z valid and done high after edge N+1. busy is high for exactly N+1 cycles. Defaults: 33 cycles; BITS_PER_CYCLE=4 gives 9.
- start while busy is ignored: operands are not re-latched and the running operation continues.
- start in the same cycle as done (state IDLE after the FIX edge) is accepted normally. Back-to-back throughput is one result every N+2 cycles.
- z holds the last result until the next FIX. It is not cleared by start.
- Signed edge cases are exact:
  - Most-negative × most-negative gives 2^(2W-2).
  - Any operand 0 gives 0 regardless of neg.
- a, b and sign may change freely after the start cycle.

Optional Feature:
- Macro MULT_EARLY_TERM_EN.
- Defined: in RUN, if the remaining b_mag is 0, the block skips to FIX. Before skipping, the accumulator is shifted right by the remaining counter*BITS_PER_CYCLE (barrel shift). Latency becomes data-dependent, minimum 2 cycles (b=0: RUN once, then FIX). Results are identical to the fixed-latency build.
- Undefined: fixed N+1 latency; no zero-detect or barrel logic is synthesised.

Decomposition:
- Shared package mult_pkg:
  - State enum {IDLE, RUN, FIX}.
  - Default WIDTH constant.
  - Function to compute the iteration count and check legality of BITS_PER_CYCLE.
- One sub-module, mult_step. It is combinational and takes mcand, the BITS_PER_CYCLE-bit multiplier digit and the accumulator. It produces the next shifted accumulator, so radix changes stay local.
- The top level holds the FSM, counter and registers.

Test Plan:
- Unsigned, defaults: a=0xFFFFFFFF, b=0xFFFFFFFF, sign=0 -> z=0xFFFFFFFE00000001, done exactly 33 cycles after the start edge, busy high 33 cycles.
- Signed: a=-3 (0xFFFFFFFD), b=5, sign=1 -> z=0xFFFFFFFFFFFFFFF1. Then a=0x80000000, b=0x80000000 -> z=0x4000000000000000.
- Start during busy: assert start with a=2, b=2 at cycle 10 of a 7×9 operation -> z=63, single done pulse, no second operation.
- Reset mid-operation: pulse reset at cycle 5 -> busy=0, z=0, no done. A following start of 6×7 gives z=42.
- BITS_PER_CYCLE=4, WIDTH=16: a=0x1234, b=0x5678 unsigned -> z=0x06260060, done 5 cycles after start.
- With MULT_EARLY_TERM_EN: a=7, b=3, sign=0 -> z=21 with done at least 2 cycles after start and before cycle 33. Without the macro, the same stimulus gives done at cycle 33.
